// File: rtl/debounce_pkg.sv
// Shared types and helpers for the level debouncer and related IO blocks.
package debounce_pkg;

   // Debouncer FSM states: the MSB doubles as the debounced level.
   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b10,
      WAIT0 = 2'b11
   } state_e;

   // Width of the qualification counter; at least one bit even for tiny counts.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/level_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module level_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw level through the chain; only the first flop sees d_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage take the previous
         // stage's old value, so the chain really is SYNC_STAGES flops deep.
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/level_debouncer.sv
// Debounces a raw asynchronous input into a clean level plus rise/fall ticks.
module level_debouncer #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic db_level,
   output logic rise_tick,
   output logic fall_tick
);

   import debounce_pkg::*;

   localparam int            CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync_in;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_level_q, db_level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   level_synchronizer #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(reset),
      .d_i  (raw_in),
      .q_o  (sync_in)
   );

   // State and qualification counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ZERO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: a sync_in change always wins over counter expiry.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ZERO: begin
            if (sync_in) begin
               state_d = WAIT1;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT1: begin
            if (!sync_in) begin
               state_d = ZERO;
            end else if (cnt_q == '0) begin
               state_d = ONE;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ONE: begin
            if (!sync_in) begin
               state_d = WAIT0;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT0: begin
            if (sync_in) begin
               state_d = ONE;
            end else if (cnt_q == '0) begin
               state_d = ZERO;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ZERO;
            cnt_d   = '0;
         end
      endcase
      db_level_d = (state_d == ONE) || (state_d == WAIT0);
   end

   // Registered level and edge ticks, aligned with the new state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_level_q <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         db_level_q <= db_level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
      end
   end

   assign db_level  = db_level_q;
   assign rise_tick = rise_q;
   assign fall_tick = fall_q;

endmodule

// File: tb/tb_level_debouncer.sv
// Self-checking bench for level_debouncer with SYNC_STAGES=2, DB_CYCLES=4.
module tb_level_debouncer;

   localparam int DB = 4;

   typedef logic [2:0] exp_t; // {db_level, rise_tick, fall_tick}

   typedef struct packed {
      logic lvl;
      logic r;
      logic f;
      int   run;
   } mstep_t;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic raw_in = 1'b0;
   logic db_level, rise_tick, fall_tick;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t exp;

   // Reference model state: a 2-deep sample pipe and a run-length of disagreeing samples.
   logic [1:0] m_sync  = 2'b00;
   logic       m_level = 1'b0;
   int         m_run   = 0;
   mstep_t     m_nxt;

   level_debouncer #(
      .SYNC_STAGES(2),
      .DB_CYCLES  (DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (raw_in),
      .db_level (db_level),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick)
   );

   always #5 clk = ~clk;

   // The level flips once DB+1 consecutive synchronized samples disagree with it.
   function automatic mstep_t model_step(input logic s, input logic lvl, input int run);
      mstep_t o;
      o.lvl = lvl;
      o.r   = 1'b0;
      o.f   = 1'b0;
      o.run = 0;
      if (s != lvl) begin
         o.run = run + 1;
         if (o.run == DB + 1) begin
            o.lvl = ~lvl;
            o.run = 0;
            o.r   = ~lvl;
            o.f   = lvl;
         end
      end
      return o;
   endfunction

   // Combinational model step from the current model state.
   always_comb m_nxt = model_step(m_sync[1], m_level, m_run);

   // Advance the model every edge and queue the outputs expected after it.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_sync  <= 2'b00;
         m_level <= 1'b0;
         m_run   <= 0;
         exp_q.delete();
      end else begin
         m_sync  <= {m_sync[0], raw_in};
         m_level <= m_nxt.lvl;
         m_run   <= m_nxt.run;
         exp_q.push_back({m_nxt.lvl, m_nxt.r, m_nxt.f});
      end
   end

   // Drive raw_in, then advance to just after the next rising edge.
   task automatic cycle(input logic v);
      raw_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      raw_in = 1'b1;
      #1;
      checks++;
      if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
         errors++;
         $display("FAIL reset_immediate: got %b expected 000", {db_level, rise_tick, fall_tick});
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held edge %0d: got %b expected 000", i, {db_level, rise_tick, fall_tick});
         end
      end
      @(negedge clk);
      reset = 1'b1;
      // Edge 1 is the first edge after release; acceptance lands on edge 1+6.
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_reset edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_reset edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (rise_tick !== 1'(i == 7) || db_level !== 1'(i >= 7)) begin
            errors++;
            $display("FAIL reset_release edge %0d: got rise=%b lvl=%b expected rise=%b lvl=%b",
                     i, rise_tick, db_level, (i == 7), (i >= 7));
         end
      end
   endtask

   task automatic test_fall();
      int rises = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b0);
         if (rise_tick === 1'b1) rises++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_fall edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_fall edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (fall_tick !== 1'(i == 7) || db_level !== 1'(i < 7)) begin
            errors++;
            $display("FAIL fall edge %0d: got fall=%b lvl=%b expected fall=%b lvl=%b",
                     i, fall_tick, db_level, (i == 7), (i < 7));
         end
      end
      checks++;
      if (rises !== 0) begin
         errors++;
         $display("FAIL fall_no_rise: got %0d rise ticks expected 0", rises);
      end
   endtask

   task automatic test_clean_rise();
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_rise edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_rise edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (rise_tick !== 1'(i == 7) || db_level !== 1'(i >= 7) || fall_tick !== 1'b0) begin
            errors++;
            $display("FAIL clean_rise edge %0d: got rise=%b lvl=%b fall=%b expected rise=%b lvl=%b fall=0",
                     i, rise_tick, db_level, fall_tick, (i == 7), (i >= 7));
         end
      end
   endtask

   task automatic test_glitch();
      // Low glitch while ONE: three low cycles, then high again.
      for (int i = 1; i <= 11; i++) begin
         cycle(i > 3);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_glitch_lo edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_glitch_lo edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if ({db_level, rise_tick, fall_tick} !== 3'b100) begin
            errors++;
            $display("FAIL glitch_lo edge %0d: got %b expected 100", i, {db_level, rise_tick, fall_tick});
         end
      end
      // Settle low, then a high glitch of three cycles.
      for (int i = 1; i <= 21; i++) begin
         cycle(i > 10 && i <= 13);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_glitch_hi edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_glitch_hi edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         if (i > 10) begin
            checks++;
            if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
               errors++;
               $display("FAIL glitch_hi edge %0d: got %b expected 000", i, {db_level, rise_tick, fall_tick});
            end
         end
      end
   endtask

   task automatic test_min_pulse();
      int rises = 0;
      int falls = 0;
      // Four high cycles: the low sample meets cnt==0 and must abort.
      for (int i = 1; i <= 14; i++) begin
         cycle(i <= 4);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pulse4 edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_pulse4 edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
            errors++;
            $display("FAIL pulse4 edge %0d: got %b expected 000", i, {db_level, rise_tick, fall_tick});
         end
      end
      // Five high cycles: the shortest accepted pulse, followed by a full fall.
      for (int i = 1; i <= 14; i++) begin
         cycle(i <= 5);
         if (rise_tick === 1'b1) rises++;
         if (fall_tick === 1'b1) falls++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pulse5 edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_pulse5 edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (rise_tick !== 1'(i == 7) || fall_tick !== 1'(i == 12)) begin
            errors++;
            $display("FAIL pulse5 edge %0d: got rise=%b fall=%b expected rise=%b fall=%b",
                     i, rise_tick, fall_tick, (i == 7), (i == 12));
         end
      end
      checks++;
      if (rises !== 1 || falls !== 1) begin
         errors++;
         $display("FAIL pulse5_count: got rises=%0d falls=%0d expected 1 and 1", rises, falls);
      end
   endtask

   task automatic test_bounce();
      logic [4:0] burst = 5'b10101; // bit 0 first
      int rises = 0;
      for (int i = 1; i <= 13; i++) begin
         cycle((i <= 5) ? burst[i-1] : 1'b1);
         if (rise_tick === 1'b1) rises++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_bounce edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_bounce edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (rise_tick !== 1'(i == 11) || db_level !== 1'(i >= 11)) begin
            errors++;
            $display("FAIL bounce edge %0d: got rise=%b lvl=%b expected rise=%b lvl=%b",
                     i, rise_tick, db_level, (i == 11), (i >= 11));
         end
      end
      checks++;
      if (rises !== 1) begin
         errors++;
         $display("FAIL bounce_count: got %0d rise ticks expected 1", rises);
      end
   endtask

   task automatic test_mid_reset();
      // Return to ZERO, then stop five edges in: WAIT1 with cnt==1.
      for (int i = 1; i <= 17; i++) begin
         cycle(i > 12);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_mid edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_mid edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_immediate: got %b expected 000", {db_level, rise_tick, fall_tick});
      end
      raw_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      // No tick after release while low; then a fresh qualification.
      for (int i = 1; i <= 18; i++) begin
         cycle(i > 10);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_mid_rel edge %0d: got empty queue expected an entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({db_level, rise_tick, fall_tick} !== exp) begin
               errors++;
               $display("FAIL sb_mid_rel edge %0d: got %b expected %b", i, {db_level, rise_tick, fall_tick}, exp);
            end
         end
         checks++;
         if (rise_tick !== 1'(i == 17) || fall_tick !== 1'b0 || db_level !== 1'(i >= 17)) begin
            errors++;
            $display("FAIL mid_release edge %0d: got rise=%b fall=%b lvl=%b expected rise=%b fall=0 lvl=%b",
                     i, rise_tick, fall_tick, db_level, (i == 17), (i >= 17));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fall();
      test_clean_rise();
      test_glitch();
      test_min_pulse();
      test_bounce();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
